mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single CPU-side RAM port (en/memwrite/adr/writedata -> memdata) between two requesters.
//  Requester 0 is the MIPS core (cpu_*). Requester 1 is the level/sprite loader DMA (dma_*).
//  Grants at most one access per clock; returns read data with the RAM's 1-cycle registered latency.
//  Sits between the core/DMA and the RAM. The pixel-clock glyph port is outside this block.
// PARAMETERS
//  WIDTH          16  data width, matches RAM word
//  RAM_ADDR_BITS  14  address width, matches RAM depth
//  MAX_BURST      8   max consecutive DMA grants in one locked burst (>=1)
//  MAX_WAIT       15  DMA wait cycles before starvation guard trips (>=1; used only with guard)
// PORTS
//  clk         in   1              system clock, all logic on posedge
//  reset       in   1              asynchronous, active-high
//  cpu_req     in   1              CPU access request; hold with cpu_we/adr/wdata stable until cpu_gnt
//  cpu_we      in   1              1=write, 0=read
//  cpu_adr     in   RAM_ADDR_BITS  CPU address
//  cpu_wdata   in   WIDTH          CPU write data
//  cpu_gnt     out  1              combinational; access issued to RAM this cycle
//  cpu_rvalid  out  1              registered; cpu_rdata valid this cycle
//  cpu_rdata   out  WIDTH          = mem_rdata; meaningful only while cpu_rvalid=1
//  dma_req     in   1              DMA request, same hold rule as cpu_req
//  dma_lock    in   1              DMA requests a locked burst
//  dma_we      in   1              1=write, 0=read
//  dma_adr     in   RAM_ADDR_BITS  DMA address
//  dma_wdata   in   WIDTH          DMA write data
//  dma_gnt     out  1              combinational grant
//  dma_rvalid  out  1              registered read-data valid
//  dma_rdata   out  WIDTH          = mem_rdata; meaningful only while dma_rvalid=1
//  mem_en      out  1              RAM enable = cpu_gnt | dma_gnt
//  mem_we      out  1              RAM memwrite, muxed from granted requester
//  mem_adr     out  RAM_ADDR_BITS  RAM address, muxed
//  mem_wdata   out  WIDTH          RAM writedata, muxed
//  mem_rdata   in   WIDTH          RAM memdata (registered inside RAM)
// BEHAVIOUR
//  Reset: state=ST_NORM, burst_cnt=0, wait_cnt=0, cpu_rvalid=dma_rvalid=0.
//   With no grant, mem_en/mem_we/mem_adr/mem_wdata=0.
//  Grants are mutually exclusive. mem_* mux selects the granted requester, else all zero.
//  ST_NORM: cpu_req -> CPU granted. Else dma_req -> DMA granted.
//   A DMA grant with dma_lock=1 -> ST_BURST, burst_cnt=1.
//  ST_BURST: DMA has priority over CPU.
//   dma_req=1 -> DMA granted, burst_cnt++.
//   dma_req=0 -> arbitrate as ST_NORM this cycle; next state ST_NORM.
//   Exit to ST_NORM, burst_cnt=0, when any of: dma_lock=0 on a grant; dma_req=0; burst_cnt reaches MAX_BURST after this grant.
//   A new burst starts only from ST_NORM, so the CPU always wins the cycle after a MAX_BURST exit if requesting.
//  Read latency: gnt in cycle N with we=0 -> rvalid=1 in cycle N+1 only (1-cycle pulse per grant).
//   Back-to-back grants give back-to-back rvalid pulses.
//  Writes: gnt only, no rvalid. rdata is a plain wire because RAM memdata also changes on writes.
//  wait_cnt: +1 per cycle with dma_req=1 and dma_gnt=0, saturating at MAX_WAIT. Clears on dma_gnt=1 or dma_req=0.
//  Counter widths: $clog2(MAX_BURST+1) for burst_cnt, $clog2(MAX_WAIT+1) for wait_cnt. No wrap.
//  Reset mid-operation: pending rvalid dropped, no spurious response. Requesters must re-request.
//  Requests dropped before grant are legal and leave no state behind, apart from the wait_cnt clear.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined: in ST_NORM, wait_cnt==MAX_WAIT with dma_req=1 -> DMA beats CPU for one grant.
//  ARB_STARVE_GUARD_EN undefined: strict CPU priority in ST_NORM.
//   wait_cnt logic is removed and the DMA can starve indefinitely.
// TESTING
//  1. Reset, CPU read 0x0010 -> same-cycle cpu_gnt, mem_en=1, mem_we=0, mem_adr=0x0010.
//     Next cycle cpu_rvalid=1, cpu_rdata=RAM[0x0010]. All dma_* outputs stay 0.
//  2. Same-cycle CPU write 0x0100=0xBEEF and DMA read 0x0200 -> cycle N cpu_gnt, mem_we=1, mem_wdata=0xBEEF.
//     N+1 dma_gnt. N+2 dma_rvalid=1. cpu_rvalid never asserts.
//  3. CPU idle, DMA locked reads 0x0000.. -> burst starts. CPU requests at burst grant 3.
//     DMA keeps grants 1..8 (MAX_BURST=8). CPU granted on cycle 9. DMA resumes after.
//  4. CPU and DMA requesting continuously, MAX_WAIT=15 -> with guard: dma_gnt in the 16th cycle, then every 16th cycle.
//     Without guard: dma_gnt=0 for 100 cycles.
//  5. Reset asserted in the cycle after a CPU read grant -> cpu_rvalid stays 0, all outputs 0.
//     After release, the next CPU read is served with 1-cycle latency.
//  6. CPU writes 0x3FFF=0x1234, then reads 0x3FFF back-to-back -> cpu_rvalid on the read only, cpu_rdata=0x1234.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single CPU-side RAM port between two requesters. Requester 0 is
// the MIPS core (cpu_*). Requester 1 is the level/sprite loader DMA (dma_*).
// At most one access is issued per clock. Read data comes back one cycle
// after the grant, which matches the RAM's registered output.
//
// Arbitration
//   ST_NORM  : the CPU wins over the DMA. A DMA grant with dma_lock=1 opens
//              a locked burst.
//   ST_BURST : the DMA wins over the CPU for up to MAX_BURST consecutive
//              grants. The burst closes on an unlocked grant, on a DMA
//              request gap, or when the grant limit is reached.
//
// Optional feature, enabled by defining ARB_STARVE_GUARD_EN:
//   A wait counter tracks how long the DMA has been refused. Once it
//   saturates at MAX_WAIT, the DMA beats the CPU for one grant in ST_NORM.
//   When the macro is undefined, the CPU has strict priority in ST_NORM.
//
// Parameters
//   WIDTH          data width (RAM word)
//   RAM_ADDR_BITS  address width (RAM depth)
//   MAX_BURST      max consecutive DMA grants in one locked burst (>=1)
//   MAX_WAIT       refused DMA cycles before the starvation guard trips (>=1)
//
// Ports
//   clk, reset                        clock, async active-high reset
//   cpu_req/we/adr/wdata              CPU request, held until cpu_gnt
//   cpu_gnt                           combinational grant
//   cpu_rvalid, cpu_rdata             registered read-valid, read data wire
//   dma_req/lock/we/adr/wdata         DMA request, held until dma_gnt
//   dma_gnt                           combinational grant
//   dma_rvalid, dma_rdata             registered read-valid, read data wire
//   mem_en/we/adr/wdata               RAM port; all zero when nothing granted
//   mem_rdata                         RAM read data (registered in the RAM)

module mem_port_arbiter #(
  parameter int WIDTH         = 16,
  parameter int RAM_ADDR_BITS = 14,
  parameter int MAX_BURST     = 8,
  parameter int MAX_WAIT      = 15
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
  input  logic [WIDTH-1:0]         cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [WIDTH-1:0]         cpu_rdata,

  input  logic                     dma_req,
  input  logic                     dma_lock,
  input  logic                     dma_we,
  input  logic [RAM_ADDR_BITS-1:0] dma_adr,
  input  logic [WIDTH-1:0]         dma_wdata,
  output logic                     dma_gnt,
  output logic                     dma_rvalid,
  output logic [WIDTH-1:0]         dma_rdata,

  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  // Reject configurations that cannot work before they reach synthesis.
  if (MAX_BURST < 1 || MAX_WAIT < 1) begin : g_param_check
    $error("mem_port_arbiter: MAX_BURST and MAX_WAIT must both be >= 1");
  end

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);
  // With MAX_BURST=1 a burst would end on its very first grant, so none opens.
  localparam bit BURST_ALLOWED = (MAX_BURST > 1);

  typedef enum logic {
    ST_NORM  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BURST_W-1:0]   burst_cnt;
  logic [BURST_W-1:0]   burst_cnt_nxt;
  logic [BURST_W-1:0]   burst_inc;
  logic                 dma_first;
  logic                 starved;

`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  assign starved = (wait_cnt == WAIT_MAX);

  // Count refused DMA cycles, saturating. Any grant or request gap clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (dma_req && !dma_gnt) begin
      if (!starved) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Grants are gated by reset so that nothing reaches the RAM while the
  // block is being reset.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    dma_first = dma_req && ((state == ST_BURST) || starved);
    if (!reset) begin
      if (dma_first) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // RAM port mux: drives zeros whenever no access is issued.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_adr   = dma_adr;
      mem_wdata = dma_wdata;
    end
  end

  // Burst tracking. In ST_BURST a DMA request always wins, so a cycle
  // without a DMA grant means the DMA dropped its request.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    burst_inc     = burst_cnt + 1'b1;
    case (state)
      ST_NORM: begin
        if (dma_gnt && dma_lock && BURST_ALLOWED) begin
          state_nxt     = ST_BURST;
          burst_cnt_nxt = BURST_W'(1);
        end
      end
      ST_BURST: begin
        if (dma_gnt && dma_lock && (burst_inc != BURST_LAST)) begin
          burst_cnt_nxt = burst_inc;
        end else begin
          state_nxt     = ST_NORM;
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_NORM;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // State register and read-valid pulses. A reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_NORM;
      burst_cnt  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
    end
  end

  // RAM data also changes on writes, so validity is carried only by rvalid.
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter with directed scenarios followed by random traffic
// and compares every cycle against a behavioural model of the arbitration
// rules and a shadow memory. A small registered RAM model sits on mem_*.
// Define ARB_STARVE_GUARD_EN for both files to exercise the starvation guard.

module tb_mem_port_arbiter;

  localparam int WIDTH     = 16;
  localparam int AW        = 14;
  localparam int MAX_BURST = 8;
  localparam int MAX_WAIT  = 15;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             cpu_req, cpu_we;
  logic [AW-1:0]    cpu_adr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_gnt, cpu_rvalid;
  logic [WIDTH-1:0] cpu_rdata;
  logic             dma_req, dma_lock, dma_we;
  logic [AW-1:0]    dma_adr;
  logic [WIDTH-1:0] dma_wdata;
  logic             dma_gnt, dma_rvalid;
  logic [WIDTH-1:0] dma_rdata;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model state
  bit               mInBurst;
  int               mBurstLen;
  int               mWaited;
  bit               mCpuRv, mDmaRv;
  logic [WIDTH-1:0] mRdata;
  logic [WIDTH-1:0] goldenMem [int];
  int               lastWinner;

  mem_port_arbiter #(
    .WIDTH(WIDTH), .RAM_ADDR_BITS(AW), .MAX_BURST(MAX_BURST), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_adr(dma_adr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of the test RAM
  function automatic logic [WIDTH-1:0] initWord(input logic [AW-1:0] a);
    return WIDTH'((32'(a) * 32'h9E37) ^ 32'h5A5A);
  endfunction

  // Registered RAM model, read-before-write
  logic [WIDTH-1:0] ram     [0:(1<<AW)-1];
  bit               written [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_adr]     <= mem_wdata;
        written[mem_adr] <= 1'b1;
      end
      mem_rdata <= written[mem_adr] ? ram[mem_adr] : initWord(mem_adr);
    end
  end

  function automatic logic [WIDTH-1:0] goldRead(input logic [AW-1:0] a);
    if (goldenMem.exists(int'(a))) return goldenMem[int'(a)];
    return initWord(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mInBurst   = 1'b0;
    mBurstLen  = 0;
    mWaited    = 0;
    mCpuRv     = 1'b0;
    mDmaRv     = 1'b0;
    lastWinner = 0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // then advance the model to what the next rising edge produces.
  task automatic applyStimulus(
    input bit cReq, input bit cWe, input logic [AW-1:0] cAdr, input logic [WIDTH-1:0] cWd,
    input bit dReq, input bit dLock, input bit dWe, input logic [AW-1:0] dAdr,
    input logic [WIDTH-1:0] dWd);
    int               winner;
    bit               dmaFirst;
    bit               expWe;
    logic [AW-1:0]    expAdr;
    logic [WIDTH-1:0] expWd;
    @(negedge clk);
    cpu_req = cReq; cpu_we = cWe; cpu_adr = cAdr; cpu_wdata = cWd;
    dma_req = dReq; dma_lock = dLock; dma_we = dWe; dma_adr = dAdr; dma_wdata = dWd;
    #1;
    dmaFirst = dReq && (mInBurst || (GUARD && mWaited >= MAX_WAIT));
    if (dmaFirst)  winner = 2;
    else if (cReq) winner = 1;
    else if (dReq) winner = 2;
    else           winner = 0;
    expWe = 1'b0; expAdr = '0; expWd = '0;
    if (winner == 1) begin expWe = cWe; expAdr = cAdr; expWd = cWd; end
    if (winner == 2) begin expWe = dWe; expAdr = dAdr; expWd = dWd; end
    checkOutput("cpu_gnt",    32'(cpu_gnt),    32'(winner == 1));
    checkOutput("dma_gnt",    32'(dma_gnt),    32'(winner == 2));
    checkOutput("mem_en",     32'(mem_en),     32'(winner != 0));
    checkOutput("mem_we",     32'(mem_we),     32'(expWe));
    checkOutput("mem_adr",    32'(mem_adr),    32'(expAdr));
    checkOutput("mem_wdata",  32'(mem_wdata),  32'(expWd));
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(mCpuRv));
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(mDmaRv));
    if (mCpuRv) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(mRdata));
    if (mDmaRv) checkOutput("dma_rdata", 32'(dma_rdata), 32'(mRdata));
    mCpuRv = (winner == 1) && !cWe;
    mDmaRv = (winner == 2) && !dWe;
    if (winner != 0) begin
      if (!expWe) mRdata = goldRead(expAdr);
      else        goldenMem[int'(expAdr)] = expWd;
    end
    if (winner == 2) begin
      if (mInBurst) begin
        mBurstLen++;
        if (!dLock || mBurstLen >= MAX_BURST) begin
          mInBurst  = 1'b0;
          mBurstLen = 0;
        end
      end else if (dLock && MAX_BURST > 1) begin
        mInBurst  = 1'b1;
        mBurstLen = 1;
      end
    end else begin
      mInBurst  = 1'b0;
      mBurstLen = 0;
    end
    if (dReq && winner != 2) mWaited = (mWaited + 1 > MAX_WAIT) ? MAX_WAIT : mWaited + 1;
    else                     mWaited = 0;
    lastWinner = winner;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Asserts reset before the next rising edge, so a response pending from the
  // previous grant must never appear.
  task automatic doReset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
    #1;
    checkOutput("rst_mem_en",     32'(mem_en),     32'(0));
    checkOutput("rst_mem_adr",    32'(mem_adr),    32'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
    checkOutput("rst_dma_rvalid", 32'(dma_rvalid), 32'(0));
    checkOutput("rst_cpu_gnt",    32'(cpu_gnt),    32'(0));
    checkOutput("rst_dma_gnt",    32'(dma_gnt),    32'(0));
    checkOutput("rst_mem_we",     32'(mem_we),     32'(0));
    checkOutput("rst_mem_wdata",  32'(mem_wdata),  32'(0));
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [AW-1:0] dAdr;
    bit            cpuPending;
    reset = 1'b0;
    modelReset();
    #2;
    doReset();

    // 1: single CPU read
    $display("[TB] CPU read");
    applyStimulus(1, 0, 14'h0010, '0, 0, 0, 0, '0, '0);
    checkOutput("t1_cpu_gnt", 32'(cpu_gnt), 32'(1));
    checkOutput("t1_mem_adr", 32'(mem_adr), 32'h0010);
    idleCycle();
    checkOutput("t1_cpu_rvalid", 32'(cpu_rvalid), 32'(1));
    checkOutput("t1_cpu_rdata",  32'(cpu_rdata),  32'(initWord(14'h0010)));
    checkOutput("t1_dma_rvalid", 32'(dma_rvalid), 32'(0));

    // 2: CPU write collides with DMA read
    $display("[TB] CPU write vs DMA read");
    applyStimulus(1, 1, 14'h0100, 16'hBEEF, 1, 0, 0, 14'h0200, '0);
    checkOutput("t2_cpu_gnt",   32'(cpu_gnt),   32'(1));
    checkOutput("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    applyStimulus(0, 0, '0, '0, 1, 0, 0, 14'h0200, '0);
    checkOutput("t2_dma_gnt",    32'(dma_gnt),    32'(1));
    checkOutput("t2_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
    idleCycle();
    checkOutput("t2_dma_rvalid", 32'(dma_rvalid), 32'(1));
    checkOutput("t2_cpu_rvalid2", 32'(cpu_rvalid), 32'(0));

    // 3: locked DMA burst, CPU joins at burst grant 3
    $display("[TB] locked burst");
    dAdr = '0;
    cpuPending = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) cpuPending = 1'b1;
      applyStimulus(cpuPending, 0, 14'h0500, '0, 1, 1, 0, dAdr, '0);
      checkOutput("t3_cpu_gnt", 32'(cpu_gnt), 32'(k == 9));
      checkOutput("t3_dma_gnt", 32'(dma_gnt), 32'(k != 9));
      if (lastWinner == 1) cpuPending = 1'b0;
      if (lastWinner == 2) dAdr = dAdr + 1'b1;
    end
    idleCycle();
    idleCycle();

    // 4: both requesting continuously
    $display("[TB] continuous contention");
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1, 0, 14'h0700, '0, 1, 0, 0, 14'h0800, '0);
      checkOutput("t4_dma_gnt", 32'(dma_gnt), 32'(GUARD && (i % (MAX_WAIT + 1) == 0)));
    end
    idleCycle();
    idleCycle();

    // 5: reset right after a CPU read grant
    $display("[TB] reset mid-read");
    applyStimulus(1, 0, 14'h0020, '0, 0, 0, 0, '0, '0);
    doReset();
    applyStimulus(1, 0, 14'h0030, '0, 0, 0, 0, '0, '0);
    idleCycle();
    checkOutput("t5_cpu_rvalid", 32'(cpu_rvalid), 32'(1));
    checkOutput("t5_cpu_rdata",  32'(cpu_rdata),  32'(initWord(14'h0030)));

    // 6: write then read back at the top address
    $display("[TB] write/read top address");
    applyStimulus(1, 1, 14'h3FFF, 16'h1234, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 14'h3FFF, '0, 0, 0, 0, '0, '0);
    checkOutput("t6_no_rvalid_on_write", 32'(cpu_rvalid), 32'(0));
    idleCycle();
    checkOutput("t6_cpu_rvalid", 32'(cpu_rvalid), 32'(1));
    checkOutput("t6_cpu_rdata",  32'(cpu_rdata),  32'h1234);

    // Random traffic; the first half keeps the DMA busy to reach burst limits
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int dReqPct;
      if (i == 300) doReset();
      dReqPct = (i < 300) ? 95 : 60;
      applyStimulus($urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
                    14'($urandom_range(0, 63)), 16'($urandom),
                    $urandom_range(0, 99) < dReqPct, $urandom_range(0, 99) < 85,
                    $urandom_range(0, 2) == 0, 14'($urandom_range(0, 63)), 16'($urandom));
    end
    idleCycle();
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
